// File: rtl/add_sequencer.sv
`timescale 1ns/1ps
// add_sequencer: multi-cycle add/subtract controller. A WIDTH-bit request is
// accepted through valid/ready, folded through one SLICE-bit ripple adder over
// N = WIDTH/SLICE cycles (LSB slice first), and held with carry, zero and
// signed-overflow flags until the consumer takes it.
module add_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);

  localparam int N   = WIDTH / SLICE;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // A width that does not split into whole slices cannot be sequenced.
  if ((WIDTH % SLICE) != 0) begin : g_bad_params
    $error("add_sequencer: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_ADC = 2'b01, OP_SUB = 2'b10, OP_SBB = 2'b11} op_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // effective B (already inverted for SUB/SBB)
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] a_slice, b_slice;
  logic [SLICE:0]   slice_sum;

  // The single adder slice: operand slice selected by the counter plus the carry register.
  always_comb begin
    a_slice   = a_q[int'(cnt_q) * SLICE +: SLICE];
    b_slice   = b_q[int'(cnt_q) * SLICE +: SLICE];
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_q};
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = op[1] ? ~b : b;
          cnt_d   = '0;
          state_d = RUN;
          unique case (op_t'(op))
            OP_ADD:  carry_d = 1'b0;
            OP_ADC:  carry_d = cin;
            OP_SUB:  carry_d = 1'b1;
            OP_SBB:  carry_d = ~cin;
            default: carry_d = 1'b0;
          endcase
        end
      end
      RUN: begin
        res_d[int'(cnt_q) * SLICE +: SLICE] = slice_sum[SLICE-1:0];
        carry_d = slice_sum[SLICE];
        if (cnt_q == LAST) begin
          // slice_sum[SLICE-1] is the MSB of the finished result on the last slice.
          cout_d  = slice_sum[SLICE];
          ovf_d   = (a_q[MSB] == b_q[MSB]) && (slice_sum[SLICE-1] != a_q[MSB]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res       = res_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = ~|res_q;

endmodule

// File: tb/tb_add_sequencer.sv
`timescale 1ns/1ps
// Bench for add_sequencer: directed vector table and corner sequences on a
// 32/8 instance, plus random sweeps on 32/8, 16/4 and 32/32 instances, all
// checked through expected-result queues against a full-width reference model.
module tb_add_sequencer;

  localparam int N = 4;

  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic        zero;
    logic        ovf;
  } exp_t;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    exp_t        exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rst_n, in_valid, in_ready, out_valid, out_ready, cin, cout, zero, ovf, busy;
  logic [31:0] a, b, res;
  logic [1:0]  op;
  exp_t        sb_q[$];

  add_sequencer #(.WIDTH(32), .SLICE(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .cout(cout), .zero(zero), .ovf(ovf), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: one full-width addition, independent of slicing.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic c, input int w);
    exp_t        r;
    logic [31:0] mask, am, beff;
    logic [32:0] full;
    logic        c0;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    am   = x & mask;
    beff = (o[1] ? ~y : y) & mask;
    case (o)
      2'b00:   c0 = 1'b0;
      2'b01:   c0 = c;
      2'b10:   c0 = 1'b1;
      default: c0 = ~c;
    endcase
    full   = {1'b0, am} + {1'b0, beff} + {32'b0, c0};
    r.res  = full[31:0] & mask;
    r.cout = full[w];
    r.zero = (r.res == 32'h0);
    r.ovf  = (am[w-1] == beff[w-1]) && (r.res[w-1] != am[w-1]);
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drive one request, record its expectation, and scramble inputs after acceptance.
  task automatic send(input string name, input logic [1:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic c, input exp_t e);
    int guard = 0;
    sb_q.push_back(e);
    op = o; a = x; b = y; cin = c; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check({name, " accept timeout"}, 64'(guard), 64'd0);
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom); cin = 1'($urandom);
  endtask

  // Called right after the acceptance edge; counts cycles until out_valid.
  task automatic wait_out(input string name, input int exp_lat);
    int lat = 0;
    int not_busy = 0;
    while (!out_valid && lat < 50) begin
      if (!busy) not_busy++;
      tick();
      lat++;
    end
    if (!busy) not_busy++;
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy"}, 64'(not_busy), 64'd0);
  endtask

  task automatic take(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({name, " scoreboard empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check({name, " res"},  64'(res),  64'(e.res));
      check({name, " cout"}, 64'(cout), 64'(e.cout));
      check({name, " zero"}, 64'(zero), 64'(e.zero));
      check({name, " ovf"},  64'(ovf),  64'(e.ovf));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " out_valid after take"}, 64'(out_valid), 64'd0);
    check({name, " in_ready after take"},  64'(in_ready),  64'd1);
  endtask

  // Random sweep per parameter set, each with its own instance and queue.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SW = (g == 1) ? 16 : 32;
    localparam int SS = (g == 0) ? 8 : (g == 1) ? 4 : 32;
    localparam int NS = SW / SS;

    logic          rst_s, iv, ir, ov, orr, cc, co, zz, of, bs;
    logic [1:0]    oo;
    logic [SW-1:0] aa, bb, rr;
    logic          done = 1'b0;
    exp_t          q[$];

    add_sequencer #(.WIDTH(SW), .SLICE(SS)) u_sweep (
      .clk(clk), .rst_n(rst_s), .in_valid(iv), .in_ready(ir),
      .a(aa), .b(bb), .op(oo), .cin(cc), .out_valid(ov), .out_ready(orr),
      .res(rr), .cout(co), .zero(zz), .ovf(of), .busy(bs)
    );

    initial begin
      string tag;
      tag = $sformatf("w%0d_s%0d", SW, SS);
      rst_s = 1'b0; iv = 1'b0; orr = 1'b0; aa = '0; bb = '0; oo = 2'b00; cc = 1'b0;
      tick(); tick();
      rst_s = 1'b1;
      tick();
      for (int i = 0; i < 1000; i++) begin
        logic [31:0] ra, rb;
        exp_t        e;
        int          guard, lat, not_busy;
        ra = pick(); rb = pick();
        oo = 2'($urandom); cc = 1'($urandom);
        aa = ra[SW-1:0]; bb = rb[SW-1:0];
        q.push_back(model(oo, 32'(aa), 32'(bb), cc, SW));
        iv = 1'b1;
        guard = 0;
        while (!ir && guard < 50) begin
          tick();
          guard++;
        end
        if (guard >= 50) check({tag, " accept timeout"}, 64'(guard), 64'd0);
        tick();
        iv = 1'b0;
        aa = SW'($urandom); bb = SW'($urandom); oo = 2'($urandom); cc = 1'($urandom);
        lat = 0;
        not_busy = 0;
        while (!ov && lat < 50) begin
          if (!bs) not_busy++;
          tick();
          lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(NS));
        check({tag, " busy"}, 64'(not_busy), 64'd0);
        e = q.pop_front();
        check({tag, " res"},  64'(rr), 64'(e.res));
        check({tag, " cout"}, 64'(co), 64'(e.cout));
        check({tag, " zero"}, 64'(zz), 64'(e.zero));
        check({tag, " ovf"},  64'(of), 64'(e.ovf));
        repeat ($urandom_range(0, 2)) tick();
        orr = 1'b1;
        tick();
        orr = 1'b0;
      end
      done = 1'b1;
    end
  end

  vec_t vecs[12];

  initial begin
    int   bad, guard;
    exp_t e;

    vecs[0]  = '{"add_wrap",    2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b0}};
    vecs[1]  = '{"adc_ovf",     2'b01, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, '{32'h8000_0000, 1'b0, 1'b0, 1'b1}};
    vecs[2]  = '{"sub_neg",     2'b10, 32'h0000_0005, 32'h0000_0007, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
    vecs[3]  = '{"sbb_borrow",  2'b11, 32'h0000_0100, 32'h0000_0001, 1'b1, '{32'h0000_00FE, 1'b1, 1'b0, 1'b0}};
    vecs[4]  = '{"add_small",   2'b00, 32'h0000_0003, 32'h0000_0004, 1'b0, '{32'h0000_0007, 1'b0, 1'b0, 1'b0}};
    vecs[5]  = '{"sub_equal",   2'b10, 32'h1234_5678, 32'h1234_5678, 1'b1, '{32'h0000_0000, 1'b1, 1'b1, 1'b0}};
    vecs[6]  = '{"add_minmin",  2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, '{32'h0000_0000, 1'b1, 1'b1, 1'b1}};
    vecs[7]  = '{"sub_min1",    2'b10, 32'h8000_0000, 32'h0000_0001, 1'b0, '{32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1}};
    vecs[8]  = '{"adc_slice",   2'b01, 32'h0000_00FF, 32'h0000_0000, 1'b1, '{32'h0000_0100, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{"sbb_noborr",  2'b11, 32'h0000_000A, 32'h0000_0003, 1'b0, '{32'h0000_0007, 1'b1, 1'b0, 1'b0}};
    vecs[10] = '{"add_cin_ign", 2'b00, 32'h0000_0001, 32'h0000_0001, 1'b1, '{32'h0000_0002, 1'b0, 1'b0, 1'b0}};
    vecs[11] = '{"sbb_zero",    2'b11, 32'h0000_0000, 32'h0000_0000, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = 2'b00; cin = 1'b0;
    tick(); tick();
    check("reset in_ready",  64'(in_ready),  64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy",      64'(busy),      64'd0);
    check("reset res",       64'(res),       64'd0);
    check("reset cout",      64'(cout),      64'd0);
    check("reset zero",      64'(zero),      64'd1);
    check("reset ovf",       64'(ovf),       64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);
      wait_out(vecs[i].name, N);
      take(vecs[i].name);
    end

    // Backpressure: result and flags hold while a second request waits.
    send("bp", 2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0, '{32'h3333_3333, 1'b0, 1'b0, 1'b0});
    wait_out("bp", N);
    sb_q.push_back('{32'h0000_0007, 1'b0, 1'b0, 1'b0});
    op = 2'b00; a = 32'd3; b = 32'd4; cin = 1'b0; in_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (res !== 32'h3333_3333 || cout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0 ||
          in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    check("bp stall stable", 64'(bad), 64'd0);
    take("bp");
    check("bp held not yet accepted", 64'(busy), 64'd0);
    tick();
    in_valid = 1'b0;
    check("bp held accepted", 64'(busy), 64'd1);
    wait_out("bp_held", N);
    take("bp_held");

    // Reset one edge after the second slice is registered.
    send("rst", 2'b00, 32'h0102_0304, 32'h1020_3040, 1'b0, '{32'h1122_3344, 1'b0, 1'b0, 1'b0});
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("midrst in_ready",  64'(in_ready),  64'd1);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst busy",      64'(busy),      64'd0);
    check("midrst res",       64'(res),       64'd0);
    check("midrst cout",      64'(cout),      64'd0);
    check("midrst ovf",       64'(ovf),       64'd0);
    check("midrst zero",      64'(zero),      64'd1);
    rst_n = 1'b1;
    void'(sb_q.pop_back());
    bad = 0;
    repeat (6) begin
      tick();
      if (out_valid) bad++;
    end
    check("midrst nothing emitted", 64'(bad), 64'd0);
    send("post_rst", 2'b00, 32'd3, 32'd4, 1'b0, '{32'h0000_0007, 1'b0, 1'b0, 1'b0});
    wait_out("post_rst", N);
    take("post_rst");
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    guard = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && guard < 40000) begin
      tick();
      guard++;
    end
    if (guard >= 40000) check("sweep timeout", 64'(guard), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_sequencer.md
# add_sequencer

Multi-cycle adder controller for the integer datapath. It accepts one WIDTH-bit add/subtract request through a valid/ready handshake. It sequences a single SLICE-bit ripple-carry adder slice over WIDTH/SLICE cycles, LSB slice first, holding the inter-slice carry in a register. It then presents the result with carry, zero and signed-overflow flags until the consumer takes it. This trades latency for area on cores that cannot afford a full-width ripple chain.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of SLICE.
- SLICE, 8: bits processed per cycle; N = WIDTH/SLICE slices.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  one clock; reset is synchronous and active-low.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  00 ADD, 01 ADC (add with cin), 10 SUB, 11 SBB (subtract with borrow).
- cin  input  1  carry/borrow in; used only for ADC/SBB.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- res  output  WIDTH  sum/difference.
- cout  output  1  final carry out of MSB slice.
- zero  output  1  res == 0.
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. A slice counter of width clog2(N) (minimum 1) selects the active slice.
- IDLE: in_ready = 1. When in_valid && in_ready, capture a, the effective B and the initial carry, then go to RUN with counter = 0.
  - ADD: B_eff = b, c0 = 0.
  - ADC: B_eff = b, c0 = cin.
  - SUB: B_eff = ~b, c0 = 1.
  - SBB: B_eff = ~b, c0 = ~cin. cin = 1 means borrow.
- RUN: each cycle, add slice k of A and B_eff with the carry register. Write the SLICE-bit sum into res[k*SLICE +: SLICE] and update the carry register. Increment k.
  - After slice N-1, latch cout and ovf and go to DONE.
  - ovf = (A[MSB] == B_eff[MSB]) && (res[MSB] != A[MSB]).
- DONE: out_valid = 1. res, cout, zero and ovf stay stable until out_valid && out_ready, then go to IDLE.
- zero is derived from the complete res and is valid whenever out_valid = 1.
- For SUB/SBB, cout is the raw adder carry: 1 = no borrow, 0 = borrow.
- Operands are captured at acceptance. Changes on a/b/op/cin during RUN or DONE are ignored.
- in_ready = 0 in RUN and DONE. A request held during those states waits and is not dropped.
- Reset (rst_n = 0 at a rising edge), including mid-RUN or in DONE:
  - State goes to IDLE, counter and carry register clear to 0.
  - res = 0, cout = 0, ovf = 0, out_valid = 0.
  - In-flight operation is discarded; nothing is emitted for it.
- Reset values of outputs: in_ready = 1 (IDLE), out_valid = 0, busy = 0, res = 0, cout = 0, zero = 1, ovf = 0.
- Illegal parameters: WIDTH % SLICE != 0 triggers an elaboration-time error.

## Timing
- Acceptance at edge E0 (in_valid && in_ready). RUN occupies the cycles after E0 through E(N-1).
- Slice k is registered at edge E(k+1). DONE is entered at edge EN, so out_valid rises N cycles after acceptance (4 for defaults).
- out_valid and res come from registers; there is no combinational path from inputs to outputs.
- in_ready depends only on state, not on in_valid.
- Output handshake at edge E(N+1) at the earliest. State returns to IDLE and in_ready = 1 in the next cycle.
- Earliest next acceptance is edge E(N+2), so maximum throughput is one operation per N+2 cycles.
- out_ready is ignored when out_valid = 0. in_valid is ignored when in_ready = 0.
- Reset has priority over every handshake in the same cycle.

## Test plan
- ADD overflow into carry: a = 0xFFFFFFFF, b = 0x00000001 -> res = 0x00000000, cout = 1, zero = 1, ovf = 0. out_valid rises exactly 4 cycles after acceptance; busy is high throughout.
- Signed overflow and ADC: a = 0x7FFFFFFF, b = 0 with ADC, cin = 1 -> res = 0x80000000, cout = 0, ovf = 1, zero = 0.
- SUB/SBB borrow chain:
  - a = 5, b = 7, SUB -> res = 0xFFFFFFFE, cout = 0, ovf = 0.
  - Then a = 0x00000100, b = 0x00000001, SBB, cin = 1 -> res = 0x000000FE, cout = 1.
  - This checks carry propagation across the slice boundary.
- Backpressure and operand capture:
  - Hold out_ready = 0 for 10 cycles after out_valid: res and flags stay stable, in_ready stays 0.
  - Change a/b during RUN: result is unaffected.
  - Assert out_ready: the next acceptance occurs no earlier than 2 cycles later.
- Reset mid-operation: assert rst_n = 0 one edge after the 2nd slice completes -> next cycle state is IDLE, in_ready = 1, out_valid = 0, res = 0, cout = 0, ovf = 0, zero = 1. A fresh ADD 3 + 4 then returns 7.
- Randomized plus parameter sweep: 1000 random op/a/b/cin at (32,8), (16,4) and (32,32). Compare against a reference model for res, cout, ovf and zero, and check latency = N cycles.
